// File: rtl/som_sweep_ctrl.sv
// rtl/som_sweep_ctrl.sv - self-test sweep sequencer for the decoder-based SOP block
// Drives all 16 ABCD vectors with E=0 then E=1 and checks F against EXPECTED.
module som_sweep_ctrl #(
  parameter logic [15:0] EXPECTED = 16'hF830,
  parameter int          SETTLE   = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        abort,
  input  logic        f_in,
  output logic        a_out,
  output logic        b_out,
  output logic        c_out,
  output logic        d_out,
  output logic        e_out,
  output logic        busy,
  output logic        done,
  output logic [15:0] tt_out,
  output logic        pass,
  output logic        err_dis,
  output logic [3:0]  err_idx,
  output logic [4:0]  mismatch_cnt
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [3:0] HOLD_MAX = 4'(SETTLE);

  state_t     state;
  logic [3:0] idx;
  logic [3:0] hold;
  logic       phase;
  logic       last_cycle;
  logic       samp_mis;
  logic       final_samp;

  // Vector index and phase are the drive registers, so a..e_out are registered
  // and read zero whenever the sequencer is not running.
  assign a_out = idx[3];
  assign b_out = idx[2];
  assign c_out = idx[1];
  assign d_out = idx[0];
  assign e_out = phase;

  assign last_cycle = (hold == HOLD_MAX);
  assign samp_mis   = phase & (f_in != EXPECTED[idx]);
  assign final_samp = last_cycle & phase & (idx == 4'hF);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      idx          <= 4'd0;
      hold         <= 4'd0;
      phase        <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      tt_out       <= 16'd0;
      pass         <= 1'b0;
      err_dis      <= 1'b0;
      err_idx      <= 4'd0;
      mismatch_cnt <= 5'd0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (abort) begin
            state <= IDLE;
            done  <= 1'b0;
            pass  <= 1'b0;
          end else if (start) begin
            state        <= RUN;
            busy         <= 1'b1;
            done         <= 1'b0;
            pass         <= 1'b0;
            tt_out       <= 16'd0;
            err_dis      <= 1'b0;
            err_idx      <= 4'd0;
            mismatch_cnt <= 5'd0;
            idx          <= 4'd0;
            phase        <= 1'b0;
            hold         <= 4'd0;
          end
        end
        RUN: begin
          if (abort) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
            pass  <= 1'b0;
            idx   <= 4'd0;
            phase <= 1'b0;
            hold  <= 4'd0;
          end else if (!last_cycle) begin
            hold <= hold + 4'd1;
          end else begin
            hold <= 4'd0;
            if (!phase) begin
              if (f_in) err_dis <= 1'b1;
            end else begin
              tt_out[idx] <= f_in;
              if (samp_mis) begin
                mismatch_cnt <= mismatch_cnt + 5'd1;
                if (mismatch_cnt == 5'd0) err_idx <= idx;
              end
            end
            // The final sample's own mismatch is folded into pass here.
            if (final_samp) begin
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
              pass  <= !err_dis && (mismatch_cnt == 5'd0) && !samp_mis;
              idx   <= 4'd0;
              phase <= 1'b0;
            end else begin
              idx <= idx + 4'd1;
              if (idx == 4'hF) phase <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_som_sweep_ctrl.sv
// tb/tb_som_sweep_ctrl.sv - directed table-driven bench for som_sweep_ctrl
module tb_som_sweep_ctrl;

  logic clk = 1'b0;
  logic rst, abort;
  logic start_m, start_z, start_o;
  int   mode_m, mode_z;

  always #5 clk = ~clk;

  // mode 0: gated SOP, 1: forced high at idx 2 when E=1, 2: ungated
  function automatic logic fmodel(input logic a, b, c, d, e, input int mode);
    logic f;
    f = (a & ((c & d) | b)) | (b & ~c);
    if (mode == 1 && e && {a, b, c, d} == 4'b0010) f = 1'b1;
    return (mode == 2) ? f : (f & e);
  endfunction

  logic m_a, m_b, m_c, m_d, m_e, m_busy, m_done, m_pass, m_dis, m_f;
  logic [15:0] m_tt; logic [3:0] m_eidx; logic [4:0] m_cnt;
  logic z_a, z_b, z_c, z_d, z_e, z_busy, z_done, z_pass, z_dis, z_f, z_fd;
  logic [15:0] z_tt; logic [3:0] z_eidx; logic [4:0] z_cnt;
  logic o_a, o_b, o_c, o_d, o_e, o_busy, o_done, o_pass, o_dis, o_fd;
  logic [15:0] o_tt; logic [3:0] o_eidx; logic [4:0] o_cnt;

  assign m_f = fmodel(m_a, m_b, m_c, m_d, m_e, mode_m);
  assign z_f = (mode_z == 3) ? z_fd : fmodel(z_a, z_b, z_c, z_d, z_e, 0);

  always @(posedge clk or posedge rst)
    if (rst) begin
      z_fd <= 1'b0;
      o_fd <= 1'b0;
    end else begin
      z_fd <= fmodel(z_a, z_b, z_c, z_d, z_e, 0);
      o_fd <= fmodel(o_a, o_b, o_c, o_d, o_e, 0);
    end

  som_sweep_ctrl u_main (
    .clk(clk), .rst(rst), .start(start_m), .abort(abort), .f_in(m_f),
    .a_out(m_a), .b_out(m_b), .c_out(m_c), .d_out(m_d), .e_out(m_e),
    .busy(m_busy), .done(m_done), .tt_out(m_tt), .pass(m_pass),
    .err_dis(m_dis), .err_idx(m_eidx), .mismatch_cnt(m_cnt));

  som_sweep_ctrl #(.SETTLE(0)) u_s0 (
    .clk(clk), .rst(rst), .start(start_z), .abort(abort), .f_in(z_f),
    .a_out(z_a), .b_out(z_b), .c_out(z_c), .d_out(z_d), .e_out(z_e),
    .busy(z_busy), .done(z_done), .tt_out(z_tt), .pass(z_pass),
    .err_dis(z_dis), .err_idx(z_eidx), .mismatch_cnt(z_cnt));

  som_sweep_ctrl #(.SETTLE(1)) u_s1 (
    .clk(clk), .rst(rst), .start(start_o), .abort(abort), .f_in(o_fd),
    .a_out(o_a), .b_out(o_b), .c_out(o_c), .d_out(o_d), .e_out(o_e),
    .busy(o_busy), .done(o_done), .tt_out(o_tt), .pass(o_pass),
    .err_dis(o_dis), .err_idx(o_eidx), .mismatch_cnt(o_cnt));

  int n_cmp = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  typedef struct {
    int          mode;
    logic [15:0] tt;
    logic        pass;
    logic        dis;
    logic [4:0]  cnt;
    logic [3:0]  eidx;
  } vec_t;

  vec_t vecs[4];

  task automatic run_main(output int cyc);
    @(negedge clk) start_m = 1'b1;
    @(negedge clk) start_m = 1'b0;
    cyc = 0;
    while (m_busy && cyc < 1000) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  int cyc;

  initial begin
    vecs[0] = '{0, 16'hF830, 1'b1, 1'b0, 5'd0, 4'd0};
    vecs[1] = '{1, 16'hF834, 1'b0, 1'b0, 5'd1, 4'd2};
    vecs[2] = '{2, 16'hF830, 1'b0, 1'b1, 5'd0, 4'd0};
    vecs[3] = '{0, 16'hF830, 1'b1, 1'b0, 5'd0, 4'd0};

    rst = 1'b1; abort = 1'b0;
    start_m = 1'b0; start_z = 1'b0; start_o = 1'b0;
    mode_m = 0; mode_z = 0;
    repeat (3) @(negedge clk);
    chk("reset_outputs", {m_a, m_b, m_c, m_d, m_e, m_busy, m_done, m_pass, m_dis}, 0);
    chk("reset_tt", {m_tt, m_eidx, m_cnt}, 0);
    rst = 1'b0;

    for (int i = 0; i < 4; i++) begin
      mode_m = vecs[i].mode;
      run_main(cyc);
      chk($sformatf("v%0d_busy_cycles", i), cyc, 96);
      chk($sformatf("v%0d_done", i), m_done, 1);
      chk($sformatf("v%0d_tt", i), m_tt, vecs[i].tt);
      chk($sformatf("v%0d_pass", i), m_pass, vecs[i].pass);
      chk($sformatf("v%0d_err_dis", i), m_dis, vecs[i].dis);
      chk($sformatf("v%0d_cnt", i), m_cnt, vecs[i].cnt);
      if (vecs[i].cnt != 0) chk($sformatf("v%0d_err_idx", i), m_eidx, vecs[i].eidx);
      chk($sformatf("v%0d_drive_idle", i), {m_a, m_b, m_c, m_d, m_e}, 0);
    end

    // abort 40 cycles into RUN
    mode_m = 0;
    @(negedge clk) start_m = 1'b1;
    @(negedge clk) start_m = 1'b0;
    repeat (39) @(negedge clk);
    chk("abort_pre_busy", m_busy, 1);
    abort = 1'b1;
    @(negedge clk) abort = 1'b0;
    chk("abort_busy", m_busy, 0);
    chk("abort_done", m_done, 0);
    chk("abort_e", m_e, 0);
    run_main(cyc);
    chk("after_abort_pass", m_pass, 1);
    chk("after_abort_cycles", cyc, 96);

    // asynchronous reset mid-phase-1, between edges
    @(negedge clk) start_m = 1'b1;
    @(negedge clk) start_m = 1'b0;
    repeat (60) @(negedge clk);
    chk("pre_rst_e", m_e, 1);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_outputs", {m_a, m_b, m_c, m_d, m_e, m_busy, m_done, m_pass, m_dis}, 0);
    chk("async_rst_tt", {m_tt, m_eidx, m_cnt}, 0);
    #1 rst = 1'b0;
    run_main(cyc);
    chk("after_rst_pass", m_pass, 1);
    chk("after_rst_tt", m_tt, 16'hF830);

    // SETTLE=0, combinational model
    mode_z = 0;
    @(negedge clk) start_z = 1'b1;
    @(negedge clk) start_z = 1'b0;
    cyc = 0;
    while (z_busy && cyc < 1000) begin @(negedge clk); cyc++; end
    chk("s0_comb_cycles", cyc, 32);
    chk("s0_comb_pass", z_pass, 1);
    chk("s0_comb_tt", z_tt, 16'hF830);

    // SETTLE=0, registered model: each sample sees the previous vector
    mode_z = 3;
    @(negedge clk) start_z = 1'b1;
    @(negedge clk) start_z = 1'b0;
    cyc = 0;
    while (z_busy && cyc < 1000) begin @(negedge clk); cyc++; end
    chk("s0_delay_done", z_done, 1);
    chk("s0_delay_pass", z_pass, 0);
    chk("s0_delay_tt", z_tt, 16'hF060);

    // SETTLE=1, registered model
    @(negedge clk) start_o = 1'b1;
    @(negedge clk) start_o = 1'b0;
    cyc = 0;
    while (o_busy && cyc < 1000) begin @(negedge clk); cyc++; end
    chk("s1_delay_cycles", cyc, 64);
    chk("s1_delay_pass", o_pass, 1);

    // start held high: done lasts one cycle between sweeps
    mode_m = 0;
    @(negedge clk) start_m = 1'b1;
    @(negedge clk);
    cyc = 0;
    while (!m_done && cyc < 1000) begin @(negedge clk); cyc++; end
    chk("held_first_done", m_done, 1);
    cyc = 0;
    while (m_done && cyc < 10) begin @(negedge clk); cyc++; end
    chk("held_done_width", cyc, 1);
    chk("held_restart_busy", m_busy, 1);
    start_m = 1'b0;
    cyc = 0;
    while (m_busy && cyc < 1000) begin @(negedge clk); cyc++; end
    chk("held_second_pass", m_pass, 1);

    // start and abort together in DONE: abort wins
    start_m = 1'b1; abort = 1'b1;
    @(negedge clk);
    start_m = 1'b0; abort = 1'b0;
    chk("start_abort_busy", m_busy, 0);
    chk("start_abort_done", m_done, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/som_sweep_ctrl.md
Name: som_sweep_ctrl

Overview:
Self-test sequencer for the decoder-based SOP function block F = A(CD+B)+BC' with a positive-output, positive-enable 2x4 decoder.
- Drives the block's A, B, C, D and E inputs and samples F.
- Sweeps all 16 input vectors twice: first with E=0, then with E=1.
- Builds a 16-bit truth table, compares it against an expected mask and reports pass/fail with a start/done handshake.
- Sits beside the function block inside a lab self-check wrapper and replaces the free-running stimulus loop.

Parameters:
EXPECTED, 16'hF830, expected truth table (bit m = F for {A,B,C,D}=m, A MSB); default equals F = A(CD+B)+BC'.
SETTLE, 2, extra hold cycles per vector before sampling (legal range 0..15).

Ports:
clk  input  1  system clock, rising edge.
rst  input  1  asynchronous, active-high reset.
start  input  1  sweep request; accepted only in IDLE or DONE.
abort  input  1  synchronous abort of a running sweep.
f_in  input  1  F output of the function block.
a_out  output  1  function input A (MSB of vector index).
b_out  output  1  function input B.
c_out  output  1  function input C.
d_out  output  1  function input D (LSB).
e_out  output  1  decoder enable E.
busy  output  1  high while a sweep is running.
done  output  1  high in DONE until the next accepted start.
tt_out  output  16  captured truth table from the E=1 pass.
pass  output  1  high in DONE when err_dis=0 and mismatch_cnt=0.
err_dis  output  1  sticky; F=1 was seen while E=0.
err_idx  output  4  index of the first E=1 mismatch; valid when mismatch_cnt!=0.
mismatch_cnt  output  5  count of E=1 mismatches (0..16).

Behaviour:
- Reset (rst=1, async): all outputs go to 0 immediately, including all registered a..e_out. State=IDLE, idx=0, phase=0, hold counter=0.
- State machine:
  - IDLE --start & !abort--> RUN(phase 0, idx 0).
  - RUN --last sample of phase 1, idx 15--> DONE.
  - RUN --abort--> IDLE.
  - DONE --start & !abort--> RUN.
- Accepting edge: clears tt_out, err_dis, err_idx, mismatch_cnt, pass and done. Sets busy=1. Drives {a,b,c,d}_out=0 and e_out=0.
- Vector timing:
  - Each vector is held for exactly SETTLE+1 cycles.
  - f_in is sampled at the edge ending the vector's final cycle.
  - That same edge loads the next vector (idx+1). After idx 15 of phase 0 the next vector is idx 0 with e_out=1.
  - Total RUN time is 32*(SETTLE+1) cycles. With the default SETTLE this is 96 cycles.
- Phase 0 (E=0): any sampled f_in=1 sets err_dis. tt_out is untouched.
- Phase 1 (E=1):
  - tt_out[idx] <= f_in.
  - If f_in != EXPECTED[idx], mismatch_cnt increments. err_idx loads idx only when mismatch_cnt was 0.
- Final sample edge: state becomes DONE. busy=0, done=1, pass is registered, a..e_out=0.
- Abort in RUN: next edge goes to IDLE with busy=0, done=0, pass=0, a..e_out=0. tt_out and error fields keep their partial values.
- start during RUN is ignored. start and abort together in IDLE/DONE: abort wins and state goes to or stays in IDLE.
- start held continuously: done is high for exactly one cycle, then the next sweep begins.
- Reset asserted mid-sweep: immediate return to reset values with no partial results kept.

Test Plan:
- Golden gated model, SETTLE=2, 1-cycle start pulse -> busy high for 96 cycles, then done=1, tt_out=16'hF830, pass=1, err_dis=0, mismatch_cnt=0.
- Model with F forced to 1 at idx 4'b0010 when E=1 -> tt_out=16'hF834, mismatch_cnt=1, err_idx=2, pass=0.
- Model ignoring E (F ungated) -> err_dis=1, tt_out=16'hF830, mismatch_cnt=0, pass=0.
- abort asserted 40 cycles into RUN -> next edge busy=0, done=0, e_out=0; a fresh start then completes with pass=1.
- rst pulsed mid-phase-1 between clock edges -> all outputs 0 with no clock edge needed; start after release completes with pass=1.
- SETTLE=0 with a combinational model -> busy for 32 cycles, pass=1. A model with one cycle of registered F delay gives pass=0 at SETTLE=0 and pass=1 at SETTLE=1. start held high -> done pulses 1 cycle between back-to-back sweeps.
